// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, FSM state encoding and the buffered entry type
//            for the instruction fetch stage. FETCH_PARITY_EN adds perr.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;

    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e IDLE  = 2'd0;
    localparam fetch_state_e FETCH = 2'd1;
    localparam fetch_state_e DRAIN = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
`ifdef FETCH_PARITY_EN
        logic               perr;
`endif
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry synchronous FIFO of fetch_entry_t with clear.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             clear,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Issues PC-driven ROM reads under a FIFO credit rule and hands
//            buffered words to the decoder; FETCH_PARITY_EN adds parity.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_advance,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef FETCH_PARITY_EN
    ,
    input  logic               mem_rpar,
    output logic               instr_perr
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_need;
    logic              issue;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign fifo_pop    = instr_valid & instr_ready;
    // Entries already held plus the word on the bus, minus the one leaving now.
    assign credit_need = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q)
                       - (CNT_W + 1)'(fifo_pop);
    assign issue       = (state_q == FETCH) & ~flush
                       & (credit_need < (CNT_W + 1)'(DEPTH));
    assign fifo_push   = (state_q == FETCH) & inflight_q & ~flush
                       & (~fifo_full | fifo_pop);

    assign mem_req    = issue;
    assign pc_advance = issue;
    assign mem_addr   = pc_addr;

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = req_addr_q;
        push_entry.instr = mem_rdata;
`ifdef FETCH_PARITY_EN
        push_entry.perr  = ^{mem_rdata, mem_rpar};
`endif
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .nReset    (nReset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head_entry)
    );

    // Head fields are masked so an empty buffer presents zeros, not stale data.
    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_empty ? '0 : head_entry.instr;
    assign instr_addr  = fifo_empty ? '0 : head_entry.addr;
`ifdef FETCH_PARITY_EN
    assign instr_perr  = ~fifo_empty & head_entry.perr;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (flush && inflight_q) state_d = DRAIN;
            DRAIN:   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        req_addr_d = issue ? pc_addr : req_addr_q;
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a PC and ROM
//            model; parity checks are active when FETCH_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               nReset = 1'b1;
    logic [ADDR_W-1:0]  pc = '0;
    logic               pc_load = 1'b0;
    logic [ADDR_W-1:0]  pc_target = '0;
    logic               pc_advance;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] rom_data = '0;
    logic               rom_par = 1'b0;
    logic               flush = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_addr;
    logic               instr_valid;
    logic               instr_ready = 1'b1;
`ifdef FETCH_PARITY_EN
    logic               instr_perr;
`endif

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(2)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .pc_addr     (pc),
        .pc_advance  (pc_advance),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (rom_data),
        .flush       (flush),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_PARITY_EN
        ,
        .mem_rpar    (rom_par),
        .instr_perr  (instr_perr)
`endif
    );

    // Program counter: reset, jump load, or advance on the stage's enable.
    always @(posedge clk) begin
        if (nReset)          pc <= '0;
        else if (pc_load)    pc <= pc_target;
        else if (pc_advance) pc <= pc + 1'b1;
    end

    // ROM[i] = A000 + i with even parity, deliberately corrupted at address 5.
    always @(posedge clk) begin
        if (mem_req) begin
            rom_data <= 16'hA000 + {10'd0, mem_addr};
            rom_par  <= ^(16'hA000 + {10'd0, mem_addr}) ^ (mem_addr == 6'd5);
        end
    end

    always @(posedge clk) begin
        if (!nReset && instr_valid && instr_ready) hs_cnt <= hs_cnt + 1;
    end

    always @(negedge clk) begin
        if (!nReset && dut.fifo_push && dut.fifo_full && !dut.fifo_pop) begin
            failures++;
            $display("FAIL fifo_overflow observed=push_when_full expected=no_push");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        step();
        step();
        nReset = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc_adv", 32'(pc_advance), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_iaddr", 32'(instr_addr), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef FETCH_PARITY_EN
        chk("rst_perr", 32'(instr_perr), 32'd0);
`endif

        step();
        chk("c1_mem_req", 32'(mem_req), 32'd1);
        chk("c1_mem_addr", 32'(mem_addr), 32'd0);
        chk("c1_pc_adv", 32'(pc_advance), 32'd1);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("c2_mem_addr", 32'(mem_addr), 32'd1);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        step();
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", 32'(instr), 32'hA000);
        chk("c3_iaddr", 32'(instr_addr), 32'd0);
        step();
        chk("c4_instr", 32'(instr), 32'hA001);
        step();
        chk("c5_instr", 32'(instr), 32'hA002);
        chk("c5_iaddr", 32'(instr_addr), 32'd2);

        instr_ready = 1'b0;
        #1;
        chk("stall_no_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'hA002);
            chk("stall_iaddr", 32'(instr_addr), 32'd2);
            chk("stall_pc_adv", 32'(pc_advance), 32'd0);
        end
        chk("stall_count", 32'(dut.fifo_count), 32'd2);

        step();
        instr_ready = 1'b1;
        #1;
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", 32'(mem_addr), 32'd4);
        step();
        chk("resume_i3", 32'(instr), 32'hA003);
        step();
        chk("resume_i4", 32'(instr), 32'hA004);
        chk("resume_a4", 32'(instr_addr), 32'd4);
        step();
        chk("pre_flush_i5", 32'(instr), 32'hA005);

        flush     = 1'b1;
        pc_load   = 1'b1;
        pc_target = 6'd61;
        #1;
        chk("flush_no_req", 32'(mem_req), 32'd0);
        chk("flush_no_adv", 32'(pc_advance), 32'd0);
        step();
        flush   = 1'b0;
        pc_load = 1'b0;
        #1;
        chk("drain_valid", 32'(instr_valid), 32'd0);
        chk("drain_req", 32'(mem_req), 32'd0);
        chk("drain_state", 32'(dut.state_q), 32'(DRAIN));
        step();
        chk("refetch_req", 32'(mem_req), 32'd1);
        chk("refetch_addr", 32'(mem_addr), 32'd61);
        step();
        step();
        chk("jump_instr", 32'(instr), 32'hA03D);
        chk("jump_iaddr", 32'(instr_addr), 32'd61);
        step();
        step();
        chk("wrap_a63", 32'(instr_addr), 32'd63);
        chk("wrap_i63", 32'(instr), 32'hA03F);
        step();
        chk("wrap_a0", 32'(instr_addr), 32'd0);
        chk("wrap_i0", 32'(instr), 32'hA000);

        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_hs_valid", 32'(instr_valid), 32'd0);
        chk("flush_hs_count", 32'(dut.fifo_count), 32'd0);
        chk("flush_hs_total", 32'(hs_cnt), 32'd10);
        step();
        chk("post_flush_req", 32'(mem_req), 32'd1);
        chk("post_flush_addr", 32'(mem_addr), 32'd2);

        nReset = 1'b1;
        step();
        nReset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        step();
        chk("rst2_req", 32'(mem_req), 32'd1);
        chk("rst2_addr", 32'(mem_addr), 32'd0);
        step();
        step();
        chk("rst2_instr", 32'(instr), 32'hA000);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("seq_iaddr", 32'(instr_addr), 32'(i));
`ifdef FETCH_PARITY_EN
            chk("seq_perr", 32'(instr_perr), (i == 5) ? 32'd1 : 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly downstream of the program counter and upstream of the decoder. Takes the current PC value, issues reads to the synchronous program ROM, and buffers returned instruction words with their addresses in a small FIFO. Presents them to the decoder over a valid/ready handshake. Drives the PC count-enable so the PC only advances when a fetch is actually issued, and supports a flush for jumps/branches.

## Interface
- ADDR_W, 6, PC / ROM address width
- INSTR_W, 16, instruction word width
- DEPTH, 2, instruction buffer entries (minimum 2)

- clk  in  1  clock
- nReset  in  1  reset nReset, synchronous, active-high; clock clk.
- pc_addr  in  ADDR_W  current PC value
- pc_advance  out  1  PC count-enable; PC increments at the next edge when high
- mem_req  out  1  ROM read strobe
- mem_addr  out  ADDR_W  ROM read address, combinationally equal to pc_addr
- mem_rdata  in  INSTR_W  ROM data, valid exactly 1 cycle after mem_req
- mem_rpar  in  1  ROM even-parity bit (FETCH_PARITY_EN only)
- flush  in  1  discard all buffered and in-flight fetches
- instr  out  INSTR_W  instruction at FIFO head
- instr_addr  out  ADDR_W  address of instr
- instr_valid  out  1  head entry valid
- instr_ready  in  1  decoder accepts head
- instr_perr  out  1  head entry parity error (FETCH_PARITY_EN only)

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: entered on reset; no requests; unconditionally goes to FETCH next cycle.
  - FETCH: issue when occ + inflight − pop < DEPTH and flush=0.
    - occ = FIFO occupancy; inflight = 1 if mem_req was high last cycle; pop = instr_valid & instr_ready.
  - On flush with inflight=1, go to DRAIN; otherwise stay in FETCH.
  - DRAIN: the returning ROM word is discarded; no request issued; returns to FETCH next cycle.
- pc_advance = mem_req. mem_addr = pc_addr. Address wrap 63→0 is carried as-is in instr_addr.
- A response arriving in FETCH is pushed as {mem_addr of the request, mem_rdata}.
- Flush:
  - FIFO is cleared at the edge; mem_req=0 and pc_advance=0 in the flush cycle.
  - A handshake in the same cycle still counts as consumed.
  - Flush has priority over push and issue.
- Reset mid-operation: FIFO cleared, in-flight response discarded, state IDLE.
- Response-free FIFO overflow cannot occur under the credit rule; the bench asserts on it.

## Timing
- Reset values: mem_req 0, pc_advance 0, instr_valid 0, instr 0, instr_addr 0, instr_perr 0, state IDLE.
- Sequence after reset release (cycle 0 = first cycle with nReset=0):
  - cycle 0: IDLE.
  - cycle 1: first mem_req.
  - cycle 2: data returned.
  - cycle 3: instr_valid=1.
- Issue-to-valid latency: 2 cycles.
- Steady state with instr_ready=1: one instruction per cycle, no bubbles.
- instr / instr_addr are held stable while instr_valid=1 and instr_ready=0.
- After flush in cycle N: instr_valid=0 in N+1; next mem_req no earlier than N+1 (N+2 if DRAIN).

## Configuration
- FETCH_PARITY_EN defined:
  - Ports mem_rpar and instr_perr exist.
  - Each pushed entry stores perr = ^{mem_rdata, mem_rpar}; instr_perr reflects the head entry.
  - Erroneous words are still delivered; the decoder decides what to do with them.
- Undefined: no parity ports, no perr storage.

## Structure
- Package fetch_pkg:
  - ADDR_W, INSTR_W
  - fetch_state_e {IDLE, FETCH, DRAIN}
  - fetch_entry_t {addr, instr, perr (under macro)}
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count, head.

## Test plan
- Reset release, ready=1, ROM[i]=16'hA000+i -> mem_req from cycle 1; instr 16'hA000 at cycle 3, then A001, A002 on consecutive cycles.
- Hold ready=0 for 5 cycles -> exactly DEPTH=2 words buffered; pc_advance stays 0 once credit is exhausted; head stable; resume delivers the next address without a gap.
- pc_addr reaches 6'd63 -> instr_addr 63 followed by 0; ROM[0] word delivered.
- flush asserted with a request in flight -> DRAIN one cycle; stale word never appears; instr_valid=0 the next cycle; fetch restarts at the new pc_addr.
- Flush coincident with a handshake -> consumed word counted once; FIFO empty afterwards.
- FETCH_PARITY_EN: corrupt mem_rpar on address 5 -> instr_perr=1 only with instr_addr=5.
